// File: rtl/layer_mac_scheduler_if.sv
// ----------------------------------------------------------------------------
// layer_mac_scheduler_if
//   Bundles the layer request, the weight/bias ROM read ports and the result
//   stream of layer_mac_scheduler.
//   slave  : the scheduler side (consumes start/in_vec/rdata, drives the rest)
//   master : the surrounding layer fabric (input buffer, ROMs, next layer)
// Signals
//   start      layer request, accepted only while the scheduler is idle
//   in_vec     IN_SIZE x 16-bit signed inputs, sampled on the accept cycle
//   w_addr     weight ROM address (n*IN_SIZE+i)
//   w_rdata    weight ROM data, one cycle after w_addr
//   b_addr     bias ROM address (current neuron)
//   b_rdata    bias ROM data, one cycle after b_addr
//   busy       layer in progress
//   out_valid  one-cycle strobe qualifying out_idx/out_data
//   out_idx    neuron index of out_data
//   out_data   saturated signed Q8 neuron result
//   done       one-cycle pulse after the last neuron's strobe
// ----------------------------------------------------------------------------
interface layer_mac_scheduler_if #(
    parameter int IN_SIZE     = 16,
    parameter int NUM_NEURONS = 10
);
    localparam int AW = $clog2(IN_SIZE * NUM_NEURONS);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                      start;
    logic [IN_SIZE-1:0][15:0]  in_vec;
    logic [AW-1:0]             w_addr;
    logic signed [15:0]        w_rdata;
    logic [NW-1:0]             b_addr;
    logic signed [15:0]        b_rdata;
    logic                      busy;
    logic                      out_valid;
    logic [NW-1:0]             out_idx;
    logic signed [15:0]        out_data;
    logic                      done;

    modport slave (
        input  start, in_vec, w_rdata, b_rdata,
        output w_addr, b_addr, busy, out_valid, out_idx, out_data, done
    );

    modport master (
        output start, in_vec, w_rdata, b_rdata,
        input  w_addr, b_addr, busy, out_valid, out_idx, out_data, done
    );
endinterface

// File: rtl/layer_mac_scheduler.sv
// ----------------------------------------------------------------------------
// layer_mac_scheduler
//   Time-multiplexes one 16x16 signed MAC over all neurons of a dense layer.
//   The input vector is latched when a layer is accepted; weights and biases
//   are streamed from external synchronous-read ROMs (one cycle read latency).
//   Each neuron produces one saturated Q8 result strobe; a done pulse follows
//   the last neuron. Cost per neuron is IN_SIZE+2 cycles.
// Ports
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low reset (aborts any layer in flight)
//   bus     layer_mac_scheduler_if.slave (see interface header)
// Configuration
//   LAYER_RELU_EN  when defined, negative saturated results are forced to 0
//                  (hidden layers); when undefined the signed result passes
//                  unchanged (logit layer). Timing is identical either way.
// ----------------------------------------------------------------------------
module layer_mac_scheduler #(
    parameter int IN_SIZE     = 16,
    parameter int NUM_NEURONS = 10,
    parameter int SHIFT       = 8,
    parameter int ACC_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    layer_mac_scheduler_if.slave  bus
);
    localparam int IW = $clog2(IN_SIZE);
    localparam int AW = $clog2(IN_SIZE * NUM_NEURONS);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [NW-1:0]            n_q;
    logic [IW-1:0]            i_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [IN_SIZE-1:0][15:0] in_q;
    logic [AW-1:0]            w_addr_q;
    logic [NW-1:0]            b_addr_q;
    logic                     busy_q;
    logic                     out_valid_q;
    logic [NW-1:0]            out_idx_q;
    logic signed [15:0]       out_data_q;
    logic                     done_q;

    // Signed per-element view of the latched input vector.
    logic signed [15:0] in_s [IN_SIZE];

    generate
        for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_in_view
            assign in_s[gi] = in_q[gi];
        end
    endgenerate

    logic [IW-1:0]            op_idx;
    logic signed [15:0]       mul_a;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_sh;
    logic signed [ACC_W:0]    sum_d;
    logic signed [15:0]       out_data_d;

    always_comb begin
        // w_rdata always belongs to the address issued one cycle earlier:
        // index i_q-1 while streaming, the final index i_q while draining.
        op_idx = (state_q == S_DRAIN) ? i_q : i_q - IW'(1);
        mul_a  = in_s[op_idx];
        prod   = 32'(mul_a) * 32'(bus.w_rdata);
        acc_d  = acc_q + ACC_W'(prod);

        // One extra bit so the rescaled sum plus bias cannot overflow
        // before the saturation compare.
        acc_sh = acc_q >>> SHIFT;
        sum_d  = (ACC_W+1)'(acc_sh) + (ACC_W+1)'(bus.b_rdata);

        if (sum_d > SAT_MAX) begin
            out_data_d = 16'sh7FFF;
        end else if (sum_d < SAT_MIN) begin
            out_data_d = 16'sh8000;
        end else begin
            out_data_d = sum_d[15:0];
        end
`ifdef LAYER_RELU_EN
        if (out_data_d[15]) begin
            out_data_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            i_q         <= '0;
            acc_q       <= '0;
            in_q        <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        in_q     <= bus.in_vec;
                        n_q      <= '0;
                        i_q      <= '0;
                        acc_q    <= '0;
                        w_addr_q <= '0;
                        b_addr_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MAC;
                    end
                end
                S_MAC: begin
                    // No data is back yet on the first cycle of a neuron.
                    if (i_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (i_q == IW'(IN_SIZE - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        i_q      <= i_q + IW'(1);
                        w_addr_q <= w_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    acc_q   <= acc_d;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    out_data_q  <= out_data_d;
                    out_idx_q   <= n_q;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    i_q         <= '0;
                    if (n_q == NW'(NUM_NEURONS - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        // Weight rows are contiguous, so the next row starts
                        // right after the last address issued.
                        n_q      <= n_q + NW'(1);
                        b_addr_q <= b_addr_q + NW'(1);
                        w_addr_q <= w_addr_q + AW'(1);
                        state_q  <= S_MAC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_layer_mac_scheduler.sv
module tb_layer_mac_scheduler;
    localparam int IN  = 4;
    localparam int N   = 2;
    localparam int LAT = IN + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_mac_scheduler_if #(.IN_SIZE(IN), .NUM_NEURONS(N)) bus ();

    layer_mac_scheduler #(
        .IN_SIZE(IN), .NUM_NEURONS(N), .SHIFT(8), .ACC_W(32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Weight and bias ROMs with one-cycle synchronous read.
    logic signed [15:0] w_mem [IN*N];
    logic signed [15:0] b_mem [N];
    always @(posedge clk) begin
        bus.w_rdata <= w_mem[bus.w_addr];
        bus.b_rdata <= b_mem[bus.b_addr];
    end

    typedef logic signed [15:0] vec_t [IN];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int sq_idx[$];
    int sq_data[$];
    int sq_cyc[$];
    int dq_cyc[$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            sq_idx.push_back(int'(bus.out_idx));
            sq_data.push_back(int'(bus.out_data));
            sq_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) dq_cyc.push_back(cyc);
    end

`ifdef LAYER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    // Reference: dot product in 32-bit wrapping arithmetic, Q8 rescale,
    // bias add, clamp to int16, optional ReLU.
    function automatic int model(int n, vec_t v);
        int acc;
        longint r;
        acc = 0;
        for (int i = 0; i < IN; i++) acc += int'(v[i]) * int'(w_mem[n*IN + i]);
        r = longint'(acc >>> 8) + longint'(b_mem[n]);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (RELU && r < 0) r = 0;
        return int'(r);
    endfunction

    function automatic logic signed [15:0] rnd(int r);
        return 16'(int'($urandom_range(2 * r)) - r);
    endfunction

    task automatic clear_q();
        sq_idx.delete(); sq_data.delete(); sq_cyc.delete(); dq_cyc.delete();
    endtask

    task automatic set_vec(input vec_t v);
        for (int i = 0; i < IN; i++) bus.in_vec[i] = v[i];
    endtask

    task automatic fill_rom(input int wr, input int br);
        for (int k = 0; k < IN*N; k++) w_mem[k] = rnd(wr);
        for (int k = 0; k < N; k++) b_mem[k] = rnd(br);
    endtask

    task automatic launch(input vec_t v, output int a);
        set_vec(v);
        bus.start = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_dones(input int want, input int budget, output bit ok);
        int c;
        c = 0;
        while (dq_cyc.size() < want && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        ok = (dq_cyc.size() >= want);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.w_addr !== '0) begin errors++; $display("FAIL reset_w_addr: got %0d want 0", bus.w_addr); end
        checks++; if (bus.b_addr !== '0) begin errors++; $display("FAIL reset_b_addr: got %0d want 0", bus.b_addr); end
        checks++; if (bus.out_idx !== '0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
        checks++; if (bus.out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: released");
    endtask

    task automatic test_example();
        vec_t v;
        int a;
        bit ok;
        int exp_d[N];
        exp_d = '{15, 7};
        v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        for (int k = 0; k < IN*N; k++) w_mem[k] = 16'sd256;
        b_mem[0] = 16'sd5; b_mem[1] = -16'sd3;
        clear_q();
        launch(v, a);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ex_busy_hi: got %b want 1", bus.busy); end
        wait_dones(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ex_timeout: dones %0d want 1", dq_cyc.size()); end
        checks++; if (sq_idx.size() !== N) begin errors++; $display("FAIL ex_count: strobes %0d want %0d", sq_idx.size(), N); end
        for (int n = 0; n < N && n < sq_idx.size(); n++) begin
            checks++;
            if (sq_idx[n] !== n || sq_data[n] !== exp_d[n] || sq_cyc[n] - a !== (n+1)*LAT) begin
                errors++;
                $display("FAIL ex_strobe%0d: idx %0d data %0d cyc %0d want idx %0d data %0d cyc %0d",
                         n, sq_idx[n], sq_data[n], sq_cyc[n] - a, n, exp_d[n], (n+1)*LAT);
            end
            $display("example: strobe idx %0d data %0d at cycle %0d", sq_idx[n], sq_data[n], sq_cyc[n] - a);
        end
        if (dq_cyc.size() > 0) begin
            checks++;
            if (dq_cyc[0] - a !== N*LAT + 1) begin
                errors++; $display("FAIL ex_done_cyc: got %0d want %0d", dq_cyc[0] - a, N*LAT + 1);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ex_busy_lo: got %b want 0", bus.busy); end
    endtask

    task automatic test_saturation();
        int c_in[3], c_w[3], c_b0[3], c_b1[3], e0[3], e1[3];
        vec_t v;
        int a;
        bit ok;
        c_in = '{16384, -16384, -32768};
        c_w  = '{16384, 16384, -32768};
        c_b0 = '{0, 0, 123};
        c_b1 = '{0, 0, -77};
        e0   = '{32767, RELU ? 0 : -32768, 123};
        e1   = '{32767, RELU ? 0 : -32768, RELU ? 0 : -77};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < IN; i++) v[i] = 16'(c_in[k]);
            for (int j = 0; j < IN*N; j++) w_mem[j] = 16'(c_w[k]);
            b_mem[0] = 16'(c_b0[k]); b_mem[1] = 16'(c_b1[k]);
            clear_q();
            launch(v, a);
            wait_dones(1, 40, ok);
            checks++; if (!ok || sq_data.size() !== N) begin
                errors++; $display("FAIL sat%0d_count: strobes %0d want %0d", k, sq_data.size(), N);
            end else begin
                checks++; if (sq_data[0] !== e0[k]) begin errors++; $display("FAIL sat%0d_n0: got %0d want %0d", k, sq_data[0], e0[k]); end
                checks++; if (sq_data[1] !== e1[k]) begin errors++; $display("FAIL sat%0d_n1: got %0d want %0d", k, sq_data[1], e1[k]); end
                $display("saturation case %0d: out %0d %0d", k, sq_data[0], sq_data[1]);
            end
        end
    endtask

    task automatic test_random();
        vec_t v;
        int a, c, e;
        for (int l = 0; l < 4; l++) begin
            fill_rom(600, 2000);
            for (int i = 0; i < IN; i++) v[i] = rnd(3000);
            clear_q();
            launch(v, a);
            c = 0;
            // Scramble in_vec every cycle; only the latched copy may matter.
            while (dq_cyc.size() < 1 && c < 60) begin
                @(posedge clk); #1;
                for (int i = 0; i < IN; i++) bus.in_vec[i] = rnd(3000);
                c++;
            end
            checks++; if (dq_cyc.size() < 1) begin errors++; $display("FAIL rand%0d_timeout: dones 0 want 1", l); end
            checks++; if (sq_idx.size() !== N) begin errors++; $display("FAIL rand%0d_count: strobes %0d want %0d", l, sq_idx.size(), N); end
            for (int n = 0; n < N && n < sq_idx.size(); n++) begin
                e = model(n, v);
                checks++;
                if (sq_idx[n] !== n || sq_data[n] !== e || sq_cyc[n] - a !== (n+1)*LAT) begin
                    errors++;
                    $display("FAIL rand%0d_strobe%0d: idx %0d data %0d cyc %0d want idx %0d data %0d cyc %0d",
                             l, n, sq_idx[n], sq_data[n], sq_cyc[n] - a, n, e, (n+1)*LAT);
                end
                $display("random layer %0d: idx %0d data %0d expected %0d", l, sq_idx[n], sq_data[n], e);
            end
            e = model(N - 1, v);
            checks++; if (int'(bus.out_data) !== e || int'(bus.out_idx) !== N - 1) begin
                errors++; $display("FAIL rand%0d_hold: idx %0d data %0d want idx %0d data %0d", l, bus.out_idx, bus.out_data, N - 1, e);
            end
        end
    endtask

    task automatic test_start_ignored();
        vec_t v;
        int a, e;
        fill_rom(600, 2000);
        for (int i = 0; i < IN; i++) v[i] = rnd(3000);
        clear_q();
        launch(v, a);
        wait_until(a + 2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_until(a + N*LAT);
        bus.start = 1'b1;                  // sampled while in DONE
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3*LAT) @(posedge clk);
        #1;
        checks++; if (sq_idx.size() !== N || dq_cyc.size() !== 1) begin
            errors++; $display("FAIL ign_count: strobes %0d dones %0d want %0d and 1", sq_idx.size(), dq_cyc.size(), N);
        end
        for (int n = 0; n < N && n < sq_idx.size(); n++) begin
            e = model(n, v);
            checks++;
            if (sq_idx[n] !== n || sq_data[n] !== e || sq_cyc[n] - a !== (n+1)*LAT) begin
                errors++;
                $display("FAIL ign_strobe%0d: idx %0d data %0d cyc %0d want idx %0d data %0d cyc %0d",
                         n, sq_idx[n], sq_data[n], sq_cyc[n] - a, n, e, (n+1)*LAT);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", bus.busy); end
        $display("start ignored: %0d strobes, %0d dones", sq_idx.size(), dq_cyc.size());
    endtask

    task automatic test_reset_mid();
        vec_t v;
        int a, e;
        bit ok;
        fill_rom(600, 2000);
        for (int i = 0; i < IN; i++) v[i] = rnd(3000);
        clear_q();
        launch(v, a);
        wait_until(a + LAT + 5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outputs: busy %b valid %b done %b want 0 0 0", bus.busy, bus.out_valid, bus.done);
        end
        clear_q();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3*LAT) @(posedge clk);
        #1;
        checks++; if (sq_idx.size() !== 0 || dq_cyc.size() !== 0) begin
            errors++; $display("FAIL mid_rst_quiet: strobes %0d dones %0d want 0 0", sq_idx.size(), dq_cyc.size());
        end
        for (int i = 0; i < IN; i++) v[i] = rnd(3000);
        clear_q();
        launch(v, a);
        wait_dones(1, 40, ok);
        checks++; if (!ok || sq_idx.size() !== N) begin
            errors++; $display("FAIL mid_rerun_count: strobes %0d want %0d", sq_idx.size(), N);
        end
        for (int n = 0; n < N && n < sq_idx.size(); n++) begin
            e = model(n, v);
            checks++;
            if (sq_idx[n] !== n || sq_data[n] !== e || sq_cyc[n] - a !== (n+1)*LAT) begin
                errors++;
                $display("FAIL mid_rerun%0d: idx %0d data %0d cyc %0d want idx %0d data %0d cyc %0d",
                         n, sq_idx[n], sq_data[n], sq_cyc[n] - a, n, e, (n+1)*LAT);
            end
        end
        $display("reset mid-layer: rerun gave %0d strobes", sq_idx.size());
    endtask

    task automatic test_back_to_back();
        vec_t v1, v2;
        int a, a2, e, k;
        bit ok;
        fill_rom(600, 2000);
        for (int i = 0; i < IN; i++) begin v1[i] = rnd(3000); v2[i] = rnd(3000); end
        clear_q();
        set_vec(v1);
        bus.start = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        set_vec(v2);
        a2 = a + N*LAT + 2;                // one idle cycle after DONE
        wait_until(a2);
        bus.start = 1'b0;
        wait_dones(2, 60, ok);
        checks++; if (!ok || sq_idx.size() !== 2*N) begin
            errors++; $display("FAIL b2b_count: strobes %0d dones %0d want %0d and 2", sq_idx.size(), dq_cyc.size(), 2*N);
        end
        for (int s = 0; s < 2*N && s < sq_idx.size(); s++) begin
            k = s % N;
            e = (s < N) ? model(k, v1) : model(k, v2);
            checks++;
            if (sq_idx[s] !== k || sq_data[s] !== e || sq_cyc[s] - ((s < N) ? a : a2) !== (k+1)*LAT) begin
                errors++;
                $display("FAIL b2b_strobe%0d: idx %0d data %0d cyc %0d want idx %0d data %0d cyc %0d",
                         s, sq_idx[s], sq_data[s], sq_cyc[s] - ((s < N) ? a : a2), k, e, (k+1)*LAT);
            end
            $display("back-to-back: strobe %0d idx %0d data %0d", s, sq_idx[s], sq_data[s]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.in_vec = '0;
        for (int k = 0; k < IN*N; k++) w_mem[k] = '0;
        for (int k = 0; k < N; k++) b_mem[k] = '0;
        test_reset();
        test_example();
        test_saturation();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
